// File: rtl/mul_loader_pkg.sv
// Shared types and constants for the multiplier operand loader.
package mul_loader_pkg;

  localparam int unsigned WIDTH_DEF   = 224;
  localparam int unsigned WORD_DEF    = 32;
  localparam int unsigned LATENCY_DEF = 227;

  localparam int unsigned NW    = WIDTH_DEF / WORD_DEF;
  localparam int unsigned IDX_W = $clog2(NW);
  localparam int unsigned CNT_W = $clog2(LATENCY_DEF + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index width that stays at least one bit when there is a single word.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_word_deser.sv
// Word deserializer: writes successive WORD-wide beats into slots of a WIDTH-bit register.
module mul_word_deser
  import mul_loader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic [WORD-1:0]  i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last_c
);

  localparam int unsigned L_NW    = WIDTH / WORD;
  localparam int unsigned L_IDX_W = safe_clog2(L_NW);

  logic [L_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]   r_data;

  assign o_last_c = (r_idx == L_IDX_W'(L_NW - 1));
  assign o_data   = r_data;

  // Unwritten slots keep their previous contents across loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      if (i_we) begin
        r_data[WORD*32'(r_idx) +: WORD] <= i_data;
      end
      if (i_clr) begin
        r_idx <= '0;
      end else if (i_we) begin
        r_idx <= o_last_c ? '0 : L_IDX_W'(r_idx + 1'b1);
      end
    end
  end

endmodule

// File: rtl/mul_operand_loader.sv
// Operand loader / latency sequencer in front of the schoolbook multiplier.
// Optional abort input enabled by defining MUL_LOADER_ABORT_EN.
module mul_operand_loader
  import mul_loader_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned WORD    = WORD_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             mul_rst_n,
  output logic             prod_valid,
  input  logic             prod_ack
`ifdef MUL_LOADER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int unsigned L_CNT_W = $clog2(LATENCY + 1);

  if ((WIDTH % WORD) != 0 || WIDTH < WORD) begin : g_bad_width
    $error("mul_operand_loader: WIDTH must be a nonzero multiple of WORD");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("mul_operand_loader: LATENCY must be at least 1");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [L_CNT_W-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_mul_rst_n;
  logic               r_prod_valid;
  logic               w_accept;
  logic               w_we_a;
  logic               w_we_b;
  logic               w_clr;
  logic               w_last_a;
  logic               w_last_b;
  logic               w_cnt_done;

  assign in_ready   = r_in_ready;
  assign mul_rst_n  = r_mul_rst_n;
  assign prod_valid = r_prod_valid;

  assign w_accept   = in_valid && r_in_ready;
  assign w_cnt_done = (r_cnt == L_CNT_W'(LATENCY - 1));

  mul_word_deser #(.WIDTH(WIDTH), .WORD(WORD)) u_deser_a (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we_a),
    .i_clr    (w_clr),
    .i_data   (in_data),
    .o_data   (a),
    .o_last_c (w_last_a)
  );

  mul_word_deser #(.WIDTH(WIDTH), .WORD(WORD)) u_deser_b (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we_b),
    .i_clr    (w_clr),
    .i_data   (in_data),
    .o_data   (b),
    .o_last_c (w_last_b)
  );

  // Next-state and write-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_we_a      = 1'b0;
    w_we_b      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      LOAD_A: begin
        if (w_accept) begin
          w_we_a = 1'b1;
          if (w_last_a) w_state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_accept) begin
          w_we_b = 1'b1;
          if (w_last_b) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_cnt_done) w_state_nxt = DONE;
      end
      DONE: begin
        if (prod_ack) w_state_nxt = LOAD_A;
      end
      default: w_state_nxt = LOAD_A;
    endcase
`ifdef MUL_LOADER_ABORT_EN
    // Abort wins over any beat or ack in the same cycle; operand contents are kept.
    if (abort) begin
      w_state_nxt = LOAD_A;
      w_we_a      = 1'b0;
      w_we_b      = 1'b0;
      w_clr       = 1'b1;
    end
`endif
  end

  // State, latency counter and outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD_A;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_mul_rst_n  <= 1'b0;
      r_prod_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (r_state == RUN && w_state_nxt == RUN) ? L_CNT_W'(r_cnt + 1'b1) : '0;
      r_in_ready   <= (w_state_nxt == LOAD_A) || (w_state_nxt == LOAD_B);
      r_mul_rst_n  <= (w_state_nxt == RUN) || (w_state_nxt == DONE);
      r_prod_valid <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mul_operand_loader.sv
// Self-checking bench for mul_operand_loader: vector table, scoreboard, corner sequences.
module tb_mul_operand_loader;

  localparam int unsigned WIDTH = 224;
  localparam int unsigned WORD  = 32;
  localparam int unsigned NW    = WIDTH / WORD;
  localparam int unsigned LAT   = 227;
  localparam int unsigned NVEC  = 6;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               toggle;
    int unsigned      ack_hold;
    bit               ack_noise;
    int unsigned      exp_load;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WORD-1:0]  in_data = '0;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mul_rst_n;
  logic             prod_valid;
  logic             prod_ack = 1'b0;
`ifdef MUL_LOADER_ABORT_EN
  logic             abort = 1'b0;
`endif

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mul_operand_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .a          (a),
    .b          (b),
    .mul_rst_n  (mul_rst_n),
    .prod_valid (prod_valid),
    .prod_ack   (prod_ack)
`ifdef MUL_LOADER_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams a then b, least-significant word first; returns cycles used and ready-high cycles.
  task automatic load_ops(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input bit toggle, input bit ack_noise,
                          output int cycles, output int rdy_cnt);
    logic [2*WIDTH-1:0] ops;
    logic rdy;
    int beat;
    int early_run;
    ops = {bv, av};
    beat = 0;
    cycles = 0;
    rdy_cnt = 0;
    early_run = 0;
    while (beat < int'(2*NW) && cycles < 200) begin
      in_valid = !(toggle && (cycles % 2 == 0));
      in_data  = ops[WORD*beat +: WORD];
      prod_ack = ack_noise && (beat >= int'(NW));
      rdy = in_ready;
      if (rdy) rdy_cnt++;
      if (mul_rst_n !== 1'b0 || prod_valid !== 1'b0) early_run++;
      tick();
      cycles++;
      if (in_valid && rdy) beat++;
    end
    in_valid = 1'b0;
    prod_ack = 1'b0;
    check("load_beats", WIDTH'(beat), WIDTH'(2*NW));
    check("load_clear_held", WIDTH'(early_run), '0);
  endtask

  // Waits for prod_valid, optionally pulsing prod_ack during RUN.
  task automatic wait_valid(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input bit ack_noise, output int n);
    int unstable;
    n = 0;
    unstable = 0;
    while (!prod_valid && n < 1000) begin
      prod_ack = ack_noise && (n % 7 == 3);
      if (a !== av || b !== bv || mul_rst_n !== 1'b1 || in_ready !== 1'b0) unstable++;
      tick();
      n++;
    end
    prod_ack = 1'b0;
    check("run_stable", WIDTH'(unstable), '0);
  endtask

  task automatic compare_product();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", WIDTH'(1), '0);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < int'(NW); k++) begin
      check($sformatf("a_word%0d", k), WIDTH'(a[WORD*k +: WORD]), WIDTH'(e.a[WORD*k +: WORD]));
      check($sformatf("b_word%0d", k), WIDTH'(b[WORD*k +: WORD]), WIDTH'(e.b[WORD*k +: WORD]));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int rdy_cnt;
    int n;
    int hold_bad;
    sb.push_back('{v.a, v.b});
    load_ops(v.a, v.b, v.toggle, v.ack_noise, cyc, rdy_cnt);
    check("load_cycles", WIDTH'(cyc), WIDTH'(v.exp_load));
    check("ready_cycles", WIDTH'(rdy_cnt), WIDTH'(v.exp_load));
    check("run_entry", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b010));
    wait_valid(v.a, v.b, v.ack_noise, n);
    check("latency", WIDTH'(n), WIDTH'(LAT));
    if (!prod_valid) return;
    compare_product();
    hold_bad = 0;
    for (int i = 0; i < int'(v.ack_hold); i++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_0000 + 32'(i);
      tick();
      if (prod_valid !== 1'b1 || in_ready !== 1'b0 || a !== v.a || b !== v.b) hold_bad++;
    end
    in_valid = 1'b0;
    check("done_hold", WIDTH'(hold_bad), '0);
    prod_ack = 1'b1;
    tick();
    prod_ack = 1'b0;
    check("ack_release", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b100));
  endtask

  initial begin
    for (int k = 0; k < int'(NW); k++) begin
      vecs[1].a[WORD*k +: WORD] = 32'h1000 + 32'(k);
      vecs[1].b[WORD*k +: WORD] = 32'h2000 + 32'(k);
      vecs[2].a[WORD*k +: WORD] = 32'hA5A5_5A5A ^ 32'(k);
      vecs[2].b[WORD*k +: WORD] = $urandom;
      vecs[3].b[WORD*k +: WORD] = (k % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      vecs[5].a[WORD*k +: WORD] = $urandom;
      vecs[5].b[WORD*k +: WORD] = 32'hC0DE_0000 + 32'(k);
    end
    vecs[0] = '{WIDTH'(1), WIDTH'(3), 1'b0, 0, 1'b0, 14};
    vecs[1].toggle = 1'b1; vecs[1].ack_hold = 0;  vecs[1].ack_noise = 1'b0; vecs[1].exp_load = 28;
    vecs[2].toggle = 1'b0; vecs[2].ack_hold = 50; vecs[2].ack_noise = 1'b0; vecs[2].exp_load = 14;
    vecs[3].a = '1;
    vecs[3].toggle = 1'b0; vecs[3].ack_hold = 3;  vecs[3].ack_noise = 1'b1; vecs[3].exp_load = 14;
    vecs[4] = '{'0, '1, 1'b1, 1, 1'b1, 28};
    vecs[5].toggle = 1'b0; vecs[5].ack_hold = 0;  vecs[5].ack_noise = 1'b0; vecs[5].exp_load = 14;

    rst = 1'b1;
    tick();
    tick();
    check("reset_a", a, '0);
    check("reset_b", b, '0);
    check("reset_ctrl", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b100));
    rst = 1'b0;
    tick();

    for (int i = 0; i < int'(NVEC) - 1; i++) run_vec(vecs[i]);

    // Reset after 5 of 7 a beats discards the partial load.
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'h7700 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_a", a, '0);
    check("midrst_b", b, '0);
    check("midrst_ctrl", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b100));
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[5]);

`ifdef MUL_LOADER_ABORT_EN
    begin
      int cyc;
      int rc;
      int n;
      int pv_seen;
      sb.push_back('{vecs[2].a, vecs[2].b});
      load_ops(vecs[2].a, vecs[2].b, 1'b0, 1'b0, cyc, rc);
      for (int i = 0; i < 100; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_run_ctrl", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b100));
      pv_seen = 0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (prod_valid) pv_seen++;
      end
      check("abort_no_valid", WIDTH'(pv_seen), '0);
      check("abort_keep_a", a, vecs[2].a);
      void'(sb.pop_front());

      sb.push_back('{vecs[0].a, vecs[0].b});
      load_ops(vecs[0].a, vecs[0].b, 1'b0, 1'b0, cyc, rc);
      wait_valid(vecs[0].a, vecs[0].b, 1'b0, n);
      check("abort_latency", WIDTH'(n), WIDTH'(LAT));
      compare_product();
      abort    = 1'b1;
      prod_ack = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      tick();
      abort    = 1'b0;
      prod_ack = 1'b0;
      in_valid = 1'b0;
      check("abort_ack_ctrl", {in_ready, mul_rst_n, prod_valid}, WIDTH'(3'b100));
      check("abort_ack_a", a, vecs[0].a);
      run_vec(vecs[1]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_operand_loader.md
# mul_operand_loader

Upstream front end for the schoolbook large-integer multiplier. It collects two WIDTH-bit operands from a narrow word stream, presents them as stable full-width buses, and holds the multiplier in clear while loading. It then releases the multiplier, counts a fixed latency, and flags the multiplier's product output as valid until it is acknowledged downstream.

## Interface
Parameters:
- WIDTH, 224, operand width in bits; must be a multiple of WORD (elaboration error otherwise).
- WORD, 32, input beat width; NW = WIDTH/WORD beats per operand.
- LATENCY, 227, cycles in RUN from clear release to the cycle before prod_valid; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader accepts a beat.
- in_data  in  WORD  operand word, least-significant word first.
- a  out  WIDTH  operand A to the multiplier.
- b  out  WIDTH  operand B to the multiplier.
- mul_rst_n  out  1  active-low clear to the multiplier.
- prod_valid  out  1  multiplier product is final.
- prod_ack  in  1  downstream has taken the product.
- abort  in  1  present only with MUL_LOADER_ABORT_EN.

## Operation
- States: LOAD_A, LOAD_B, RUN, DONE. Reset state is LOAD_A.
- Reset values: a=0, b=0, word index=0, latency counter=0, mul_rst_n=0, prod_valid=0. in_ready decodes to 1 in LOAD_A.
- A beat is accepted when in_valid && in_ready.
- LOAD_A: beat k writes a[WORD*k +: WORD]. The beat with k = NW-1 resets k to 0 and moves to LOAD_B.
- LOAD_B: same write pattern into b. The last beat moves to RUN and clears the latency counter.
- RUN: counter increments every cycle. At counter == LATENCY-1, the state moves to DONE.
- DONE: prod_valid=1. When prod_ack=1, the state moves to LOAD_A.
- prod_ack outside DONE is ignored.
- in_ready = 1 only in LOAD_A/LOAD_B. in_valid in RUN/DONE is not consumed.
- mul_rst_n = 0 in LOAD_A/LOAD_B and 1 in RUN/DONE. All outputs are state decodes or registers; there is no combinational path from inputs to outputs.
- a/b change only on accepted beats, so they are stable throughout RUN and DONE.
- Previous operand values persist in unwritten words until overwritten. No clearing happens on a new load.
- Reset mid-operation: immediate return to reset values and LOAD_A. Partially loaded words are discarded.

## Timing
- Load phase: 2·NW accepted beats, minimum 2·NW cycles with in_valid held high (14 for the defaults).
- Edge after last b beat: RUN is entered and mul_rst_n rises in the same cycle.
- prod_valid rises exactly LATENCY cycles after RUN entry (cycle LATENCY+1 counting the RUN-entry cycle as cycle 1).
- prod_valid falls on the edge on which prod_ack is sampled high. in_ready rises in that same cycle, so back-to-back operations have no bubble.
- Throughput with the defaults and immediate ack: 14 + 227 + 1 = 242 cycles per product.

## Configuration
- MUL_LOADER_ABORT_EN defined:
  - The abort port exists.
  - abort=1 sampled at any edge, in any state, forces LOAD_A with word index 0, counter 0, mul_rst_n=0 and prod_valid=0.
  - a/b keep their contents.
  - abort has priority over a simultaneous accepted beat or prod_ack.
- MUL_LOADER_ABORT_EN undefined: no abort port and no abort logic. The sequence can only be interrupted by rst.

## Structure
- Shared package mul_loader_pkg holds:
  - the state enum type;
  - the derived constants NW, IDX_W = $clog2(NW) and CNT_W = $clog2(LATENCY+1);
  - the default WIDTH/WORD/LATENCY values.
- One sub-module is natural: mul_word_deser (WIDTH, WORD). It owns the word index and the shift-into-slot logic, and is instantiated once per operand with its own write enable. The FSM and latency counter live in the top.

## Test plan
- Reset, then stream a words 0x00000001,0,…,0 and b words 0x00000003,0,…,0 with in_valid held high → in_ready high for exactly 14 cycles; a=1, b=3; mul_rst_n rises on beat 15's cycle; prod_valid rises exactly 227 cycles later.
- in_valid toggled 1/0 every cycle during load → 28 cycles to load; every a/b word lands at the correct slot (word k = 0x1000+k, check a[32k+:32]).
- Hold prod_ack=0 for 50 cycles in DONE → prod_valid and a/b stable; in_ready=0; in_valid beats not consumed. Then ack=1 → LOAD_A next cycle.
- Assert rst for one cycle after 5 of 7 a beats → all outputs return to reset values; the following full 14-beat load produces the correct a/b.
- With MUL_LOADER_ABORT_EN, assert abort at RUN counter=100 → mul_rst_n=0 and in_ready=1 next cycle, prod_valid never rises. With abort in the same cycle as prod_ack → state LOAD_A and no extra beat accepted.
- prod_ack pulsed during LOAD_B and RUN → no state change and no prod_valid glitch.
